i2c_byte_engine: RTL and testbench
==================================

Name: i2c_byte_engine

Overview:
Bit-level I2C master that executes one register transaction per `go` on behalf of the temperature-sensor sequencer. The sequencer supplies `rw`, `n_byte`, `r_pointer`, `dev_add` and data bytes, and reads back bytes over a `ready`/`done` handshake. The engine generates START, repeated START and STOP, shifts address, pointer and data bits, and checks ACK. It drives the open-drain SCL/SDA pad enables at the chip boundary.

Parameters:
DIV, 250, clk cycles per SCL quarter-period (SCL = f_clk/(4*DIV)); legal range 2..4095.

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
go  in  1  start request; sampled only while done=1
rw  in  1  0 = register write, 1 = register read; latched at go
n_byte  in  2  data bytes 1..3; 0 = pointer-only write (rw ignored); latched at go
r_pointer  in  8  register pointer byte; latched at go
dev_add  in  7  7-bit slave address; latched at go
dwr  in  8  write data byte; captured as described under Behaviour
drd  out  8  last received byte
ready  out  1  one-clk pulse per data byte (request on write, valid on read)
done  out  1  level: 1 = idle and accepting go
ack_err  out  1  1 = slave NACK in the last transaction; cleared at go
scl_oe  out  1  1 = pull SCL low
sda_oe  out  1  1 = pull SDA low
sda_in  in  1  synchronized SDA pad level

Behaviour:
- Reset values: done=1, ready=0, drd=0, ack_err=0, scl_oe=0, sda_oe=0. Quarter counter is cleared.
- Reset mid-transaction: on the next clk both lines are released and done=1. No STOP is generated. Pending ready pulses are dropped.
- Quarter tick: a counter runs 0..DIV-1 while busy and ticks at DIV-1. All bus transitions occur on ticks.
- go with done=1: inputs are latched, ack_err is cleared, done goes 0 on the next clk and the counter restarts. go with done=0 is ignored.
- Bit cell, 4 quarters:
  - Q0: SCL low; SDA changes here only.
  - Q1: SCL low.
  - Q2, Q3: SCL released (high).
  - SDA is sampled on the tick ending Q2.
- START: SDA high / SCL high for 1 quarter, then SDA low for 1 quarter, then SCL low.
- STOP: SDA low with SCL low for 1 quarter, SCL high for 1 quarter, then SDA released for 1 quarter. done=1 on the clk after the final tick.
- States: IDLE, START, SEND, RACK, RSTART, RECV, MACK, STOP.
- Write sequence: START, {dev_add,0}, RACK, r_pointer, RACK, then n_byte × (dwr, RACK), then STOP. MSB first.
- Read sequence: START, {dev_add,0}, RACK, r_pointer, RACK, RSTART, {dev_add,1}, RACK, then n_byte × (RECV, MACK), then STOP.
  - MACK drives ACK (SDA low) on all bytes except the last, which gets NACK (released).
  - RSTART: release SDA while SCL is low, release SCL, then repeat the START pattern.
- Write handshake:
  - ready pulses 1 clk on the Q0 tick of each RACK that precedes a data byte. This gives n_byte pulses in total.
  - dwr is captured on the final tick of that RACK bit, 4×DIV clks later. The sequencer must hold dwr stable from ready+1 to that point.
- Read handshake:
  - On the tick sampling bit 0 of each received byte, drd updates and ready pulses 1 clk in the same cycle.
  - drd holds until the next byte completes or reset.
- Slave NACK (sda_in=1 at any RACK sample): ack_err=1, no further ready pulses, proceed directly to STOP.
- n_byte=0: START, address, pointer, STOP. No ready pulses.
- The engine releases SDA in RACK and RECV. It never drives SDA high.
- No clock stretching is supported; SCL is not read back.

Test Plan:
- Reset (DIV=4, no stimulus) -> done=1, ready=0, scl_oe=0, sda_oe=0, drd=0.
- Config write (dev_add=7'h4B, r_pointer=8'h01, rw=0, n_byte=2, sequencer answers ready with dwr 8'h60 then 8'h00, slave ACKs) -> bus bytes 0x96, 0x01, 0x60, 0x00 framed by START and STOP. Exactly 2 ready pulses, ack_err=0, done returns to 1.
- Temp read (r_pointer=8'h00, rw=1, n_byte=2, slave returns 0x19 then 0x80) -> bus shows 0x96, 0x00, Sr, 0x97. Ready pulses with drd=8'h19 then 8'h80. Master ACK after the first byte, NACK after the second, then STOP.
- Address NACK (slave absent) -> ack_err=1 after the 9th bit, zero ready pulses, STOP follows immediately, done=1.
- Reset asserted mid-pointer-byte -> next clk scl_oe=sda_oe=0 and done=1. A subsequent go completes a normal write.
- go pulsed while done=0 -> ignored: no restart, latched dev_add/r_pointer unchanged, transaction completes as originally requested.

Source files
------------

// File: rtl/i2c_byte_engine.sv
`default_nettype none
// ============================================================================
// Module   : i2c_byte_engine
// Purpose  : Bit-level I2C master. Runs one register transaction per go:
//            START, address, pointer, optional repeated START and data bytes,
//            then STOP. Checks slave ACKs. Drives the open-drain pad enables.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            go, rw, n_byte  - transaction request and shape (latched at go)
//            r_pointer       - register pointer byte
//            dev_add         - 7-bit slave address
//            dwr / drd       - write data in / last received byte out
//            ready           - one-clk pulse per data byte
//            done            - idle and accepting go
//            ack_err         - slave NACK seen in the last transaction
//            scl_oe, sda_oe  - 1 = pull the line low
//            sda_in          - synchronized SDA pad level
// Revision : 1.0 - initial release
// ============================================================================
module i2c_byte_engine #(
  parameter int DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       rw,
  input  logic [1:0] n_byte,
  input  logic [7:0] r_pointer,
  input  logic [6:0] dev_add,
  input  logic [7:0] dwr,
  output logic [7:0] drd,
  output logic       ready,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [2:0] {IDLE, START, SEND, RACK, RSTART, RECV, MACK, STOP} state_t;
  // Which byte of the frame the current SEND/RACK belongs to.
  typedef enum logic [1:0] {PH_WADDR, PH_PTR, PH_RADDR, PH_DATA} phase_t;

  localparam logic [11:0] c_cnt_last = 12'(DIV - 1);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  nbyte_q, nbyte_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        rw_q, rw_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [6:0]  dev_q, dev_d;
  logic        nack_q, nack_d;
  logic [7:0]  drd_q, drd_d;
  logic        ready_q, ready_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d, sda_q, sda_d;
  logic        w_tick;

  // Pad enables for a given state/quarter: {scl_oe, sda_oe}.
  function automatic logic [1:0] pad_drive(input state_t s, input logic [1:0] q,
                                           input logic sbit, input logic mack_low);
    logic scl_low;
    scl_low = (q < 2'd2);
    case (s)
      START:      pad_drive = {1'b0, q == 2'd1};
      SEND:       pad_drive = {scl_low, ~sbit};
      RACK, RECV: pad_drive = {scl_low, 1'b0};
      MACK:       pad_drive = {scl_low, mack_low};
      RSTART:     pad_drive = {q == 2'd0, q == 2'd3};
      STOP:       pad_drive = {q == 2'd0, q != 2'd2};
      default:    pad_drive = 2'b00;
    endcase
  endfunction

  assign w_tick = (state_q != IDLE) && (cnt_q == c_cnt_last);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    nbyte_d   = nbyte_q;
    bcnt_d    = bcnt_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    dev_d     = dev_q;
    nack_d    = nack_q;
    drd_d     = drd_q;
    ready_d   = 1'b0;
    ack_err_d = ack_err_q;

    if (state_q != IDLE) cnt_d = w_tick ? 12'd0 : cnt_q + 12'd1;

    if (state_q == IDLE) begin
      if (go) begin
        rw_d      = rw;
        nbyte_d   = n_byte;
        ptr_d     = r_pointer;
        dev_d     = dev_add;
        ack_err_d = 1'b0;
        cnt_d     = 12'd0;
        qtr_d     = 2'd0;
        bcnt_d    = 2'd0;
        phase_d   = PH_WADDR;
        state_d   = START;
      end
    end else if (w_tick) begin
      qtr_d = qtr_q + 2'd1;
      case (state_q)
        START: if (qtr_q == 2'd1) begin
          state_d = SEND;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          shift_d = {dev_q, 1'b0};
        end
        SEND: if (qtr_q == 2'd3) begin
          if (bit_q == 3'd7) begin
            state_d = RACK;
            if (phase_q == PH_DATA) bcnt_d = bcnt_q + 2'd1;
            // Request the next write byte as the ACK bit that precedes it begins.
            ready_d = (phase_q == PH_PTR && nbyte_q != 2'd0 && !rw_q) ||
                      (phase_q == PH_DATA && (bcnt_q + 2'd1) != nbyte_q);
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        RACK: begin
          if (qtr_q == 2'd2) nack_d = sda_in;
          if (qtr_q == 2'd3) begin
            bit_d = 3'd0;
            if (nack_q) begin
              ack_err_d = 1'b1;
              state_d   = STOP;
            end else begin
              case (phase_q)
                PH_WADDR: begin
                  phase_d = PH_PTR;
                  state_d = SEND;
                  shift_d = ptr_q;
                end
                PH_PTR: begin
                  if (nbyte_q == 2'd0) state_d = STOP;
                  else if (rw_q) state_d = RSTART;
                  else begin
                    phase_d = PH_DATA;
                    state_d = SEND;
                    shift_d = dwr;
                  end
                end
                PH_RADDR: begin
                  phase_d = PH_DATA;
                  state_d = RECV;
                end
                default: begin
                  if (bcnt_q == nbyte_q) state_d = STOP;
                  else begin
                    state_d = SEND;
                    shift_d = dwr;
                  end
                end
              endcase
            end
          end
        end
        RSTART: if (qtr_q == 2'd3) begin
          state_d = SEND;
          phase_d = PH_RADDR;
          bit_d   = 3'd0;
          shift_d = {dev_q, 1'b1};
        end
        RECV: begin
          if (qtr_q == 2'd2) begin
            shift_d = {shift_q[6:0], sda_in};
            if (bit_q == 3'd7) begin
              drd_d   = {shift_q[6:0], sda_in};
              ready_d = 1'b1;
            end
          end
          if (qtr_q == 2'd3) begin
            if (bit_q == 3'd7) begin
              state_d = MACK;
              bcnt_d  = bcnt_q + 2'd1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        MACK: if (qtr_q == 2'd3) begin
          bit_d = 3'd0;
          if (bcnt_q == nbyte_q) state_d = STOP;
          else state_d = RECV;
        end
        STOP: if (qtr_q == 2'd2) begin
          state_d = IDLE;
          qtr_d   = 2'd0;
        end
        default: state_d = IDLE;
      endcase
    end

    // Pads are registered from next-state values so they change exactly on ticks.
    {scl_d, sda_d} = pad_drive(state_d, qtr_d, shift_d[7], bcnt_d != nbyte_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= PH_WADDR;
      cnt_q     <= 12'd0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      nbyte_q   <= 2'd0;
      bcnt_q    <= 2'd0;
      rw_q      <= 1'b0;
      ptr_q     <= 8'd0;
      dev_q     <= 7'd0;
      nack_q    <= 1'b0;
      drd_q     <= 8'd0;
      ready_q   <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      nbyte_q   <= nbyte_d;
      bcnt_q    <= bcnt_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      dev_q     <= dev_d;
      nack_q    <= nack_d;
      drd_q     <= drd_d;
      ready_q   <= ready_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  assign drd     = drd_q;
  assign ready   = ready_q;
  assign done    = (state_q == IDLE);
  assign ack_err = ack_err_q;
  assign scl_oe  = scl_q;
  assign sda_oe  = sda_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_byte_engine
// Purpose  : Scoreboard bench for i2c_byte_engine. A bus monitor decodes
//            START/STOP and 9-bit frames ({ack, byte}) and acts as the slave;
//            expected bus events and read bytes are queued by the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_engine;

  localparam int DIV    = 4;
  localparam int EV_S   = 'h1000;
  localparam int EV_P   = 'h1001;
  localparam int BUDGET = 5000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       rw = 1'b0;
  logic [1:0] n_byte = 2'd0;
  logic [7:0] r_pointer = 8'd0;
  logic [6:0] dev_add = 7'd0;
  logic [7:0] dwr = 8'hFF;
  logic [7:0] drd;
  logic       ready, done, ack_err, scl_oe, sda_oe;
  logic       sda_in;
  logic       slave_low = 1'b0;

  assign sda_in = ~sda_oe & ~slave_low;

  i2c_byte_engine #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .go(go), .rw(rw), .n_byte(n_byte),
    .r_pointer(r_pointer), .dev_add(dev_add), .dwr(dwr), .drd(drd),
    .ready(ready), .done(done), .ack_err(ack_err), .scl_oe(scl_oe),
    .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_bus[$];
  int         exp_rd[$];
  logic [7:0] wr_data[$];
  logic [7:0] slave_tx[$];
  int         ready_cnt = 0;
  int         scl_rises = 0;
  bit         cur_rw = 1'b0;
  bit         slave_present = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic bus_event(input int v);
    if (exp_bus.size() > 0) check("bus", v, exp_bus.pop_front());
    else check("bus_unexpected", v, -1);
  endtask

  // Bus monitor, slave model and ready scoreboard.
  initial begin : monitor
    logic       p_scl, p_sda, scl_l, sda_l;
    int         pos;
    logic [7:0] rx, tx;
    bit         first, rd_mode, rd_drive, m_ack;
    p_scl = 1'b1; p_sda = 1'b1; pos = 0; rx = 8'd0; tx = 8'd0;
    first = 1'b0; rd_mode = 1'b0; rd_drive = 1'b0; m_ack = 1'b0;
    forever begin
      @(negedge clk);
      scl_l = ~scl_oe;
      sda_l = sda_in;
      if (reset) begin
        pos = 0; first = 1'b0; rd_mode = 1'b0; rd_drive = 1'b0; slave_low = 1'b0;
      end else if (p_scl && scl_l && p_sda && !sda_l) begin
        bus_event(EV_S);
        pos = 0; first = 1'b1; rd_mode = 1'b0; rd_drive = 1'b0; slave_low = 1'b0;
      end else if (p_scl && scl_l && !p_sda && sda_l) begin
        bus_event(EV_P);
        pos = 0; rd_mode = 1'b0; rd_drive = 1'b0; slave_low = 1'b0;
      end else if (!p_scl && scl_l) begin
        scl_rises++;
        pos++;
        if (pos <= 8) rx = {rx[6:0], sda_l};
        else begin
          bus_event({23'd0, sda_l, rx});
          m_ack = ~sda_l;
        end
      end else if (p_scl && !scl_l) begin
        if (pos == 8) slave_low = rd_mode ? 1'b0 : slave_present;
        else if (pos == 9) begin
          pos = 0;
          if (!rd_mode && first && rx[0] && slave_present) begin
            rd_mode = 1'b1; rd_drive = 1'b1;
          end else if (rd_mode && !m_ack) rd_drive = 1'b0;
          first = 1'b0;
          if (rd_mode && rd_drive && slave_tx.size() > 0) begin
            tx = slave_tx.pop_front();
            slave_low = ~tx[7];
          end else slave_low = 1'b0;
        end else if (rd_mode && rd_drive && pos >= 1 && pos <= 7) slave_low = ~tx[7-pos];
        else slave_low = 1'b0;
      end
      if (!reset && ready) begin
        ready_cnt++;
        if (cur_rw) begin
          if (exp_rd.size() > 0) check("drd", 32'(drd), exp_rd.pop_front());
          else check("ready_unexpected", 32'(drd), -1);
        end else begin
          dwr = (wr_data.size() > 0) ? wr_data.pop_front() : 8'hEE;
        end
      end
      p_scl = scl_l;
      p_sda = sda_l;
    end
  end

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("done_return", 32'(done), 1);
  endtask

  task automatic run_txn(input logic [6:0] dv, input logic [7:0] ptr, input bit r,
                         input logic [1:0] n, input bit present, input bit spurious,
                         input int exp_err, input int exp_ready);
    dev_add = dv; r_pointer = ptr; rw = r; n_byte = n;
    cur_rw = r; slave_present = present; ready_cnt = 0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    check("done_low", 32'(done), 0);
    if (spurious) begin
      repeat (60) @(negedge clk);
      dev_add = 7'h11; r_pointer = 8'h77; rw = ~r; n_byte = 2'd3;
      go = 1'b1;
      @(negedge clk); go = 1'b0;
    end
    wait_done();
    check("ack_err", 32'(ack_err), exp_err);
    check("ready_count", ready_cnt, exp_ready);
    check("bus_left", exp_bus.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    repeat (20) @(negedge clk);
    check("idle_hold", 32'(done), 1);
  endtask

  initial begin : stim
    int k;
    int base;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_done", 32'(done), 1);
    check("rst_ready", 32'(ready), 0);
    check("rst_scl", 32'(scl_oe), 0);
    check("rst_sda", 32'(sda_oe), 0);
    check("rst_drd", 32'(drd), 0);
    check("rst_ack_err", 32'(ack_err), 0);

    // Config write: 0x96 0x01 0x60 0x00
    exp_bus = {EV_S, 'h096, 'h001, 'h060, 'h000, EV_P};
    wr_data = {8'h60, 8'h00};
    run_txn(7'h4B, 8'h01, 1'b0, 2'd2, 1'b1, 1'b0, 0, 2);

    // Temperature read: master ACK then NACK
    exp_bus = {EV_S, 'h096, 'h000, EV_S, 'h097, 'h019, 'h180, EV_P};
    slave_tx = {8'h19, 8'h80};
    exp_rd = {'h19, 'h80};
    run_txn(7'h4B, 8'h00, 1'b1, 2'd2, 1'b1, 1'b0, 0, 2);
    check("drd_hold", 32'(drd), 'h80);

    // Slave absent: NACK on address, STOP straight away
    exp_bus = {EV_S, 'h196, EV_P};
    wr_data = {8'h11, 8'h22};
    run_txn(7'h4B, 8'h01, 1'b0, 2'd2, 1'b0, 1'b0, 1, 0);
    wr_data.delete();

    // Pointer-only write (rw ignored), clears the previous ack_err
    exp_bus = {EV_S, 'h096, 'h005, EV_P};
    run_txn(7'h4B, 8'h05, 1'b1, 2'd0, 1'b1, 1'b0, 0, 0);

    // Reset in the middle of the pointer byte
    exp_bus = {EV_S, 'h096};
    wr_data = {8'h60};
    dev_add = 7'h4B; r_pointer = 8'hC3; rw = 1'b0; n_byte = 2'd1;
    cur_rw = 1'b0; slave_present = 1'b1; ready_cnt = 0;
    base = scl_rises;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    k = 0;
    while (scl_rises < base + 12 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("reach_pointer", 32'(scl_rises >= base + 12), 1);
    k = 0;
    while (!scl_oe && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_scl", 32'(scl_oe), 0);
    check("midrst_sda", 32'(sda_oe), 0);
    check("midrst_done", 32'(done), 1);
    check("midrst_ready", 32'(ready), 0);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_bus_seen", exp_bus.size(), 0);
    check("midrst_ready_cnt", ready_cnt, 0);
    exp_bus.delete();
    wr_data.delete();

    // Normal 3-byte write after the aborted one
    exp_bus = {EV_S, 'h096, 'h002, 'h012, 'h034, 'h056, EV_P};
    wr_data = {8'h12, 8'h34, 8'h56};
    run_txn(7'h4B, 8'h02, 1'b0, 2'd3, 1'b1, 1'b0, 0, 3);

    // go pulsed while busy must be ignored
    exp_bus = {EV_S, 'h090, 'h003, 'h0A5, EV_P};
    wr_data = {8'hA5};
    run_txn(7'h48, 8'h03, 1'b0, 2'd1, 1'b1, 1'b1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
